// File: rtl/cpu_wb_stage_buf.sv
// Writeback stage buffer: valid/ready handshake, 2-entry skid, flush, LANES write channels, retire counter.
// Optional HI/LO write path is compiled in with `define WB_HILO_EN.
module cpu_wb_lane_wen #(
  parameter int REG_W = 5
) (
  input  logic             valid,
  input  logic             en,
  input  logic [REG_W-1:0] wreg,
  output logic             wen
);
  // r0 is hardwired, so its writes are dropped here but still retire
  assign wen = valid & en & (wreg != '0);
endmodule

module cpu_wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32,
  parameter int LANES  = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_lane_en,
  input  logic [LANES-1:0][DATA_W-1:0]  in_wdata,
  input  logic [LANES-1:0][REG_W-1:0]   in_wreg,
  input  logic [LANES-1:0][ADDR_W-1:0]  in_addr,
`ifdef WB_HILO_EN
  input  logic                          in_w_hi,
  input  logic                          in_w_lo,
  input  logic [DATA_W-1:0]             in_hi_data,
  input  logic [DATA_W-1:0]             in_lo_data,
  output logic                          out_w_hi,
  output logic                          out_w_lo,
  output logic [DATA_W-1:0]             out_hi_data,
  output logic [DATA_W-1:0]             out_lo_data,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_lane_wen,
  output logic [LANES-1:0][DATA_W-1:0]  out_wdata,
  output logic [LANES-1:0][REG_W-1:0]   out_wreg,
  output logic [LANES-1:0][ADDR_W-1:0]  out_addr,
  output logic [31:0]                   retire_cnt
);
  typedef struct packed {
    logic [LANES-1:0]             lane_en;
    logic [LANES-1:0][DATA_W-1:0] wdata;
    logic [LANES-1:0][REG_W-1:0]  wreg;
    logic [LANES-1:0][ADDR_W-1:0] addr;
`ifdef WB_HILO_EN
    logic                         w_hi;
    logic                         w_lo;
    logic [DATA_W-1:0]            hi_data;
    logic [DATA_W-1:0]            lo_data;
`endif
  } entry_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t      state;
  entry_t      main_q, skid_q, in_e;
  logic [31:0] cnt_q;
  logic [31:0] pop;
  logic        main_valid, accept, xfer;

  always_comb begin
    in_e         = '0;
    in_e.lane_en = in_lane_en;
    in_e.wdata   = in_wdata;
    in_e.wreg    = in_wreg;
    in_e.addr    = in_addr;
`ifdef WB_HILO_EN
    in_e.w_hi    = in_w_hi;
    in_e.w_lo    = in_w_lo;
    in_e.hi_data = in_hi_data;
    in_e.lo_data = in_lo_data;
`endif
  end

  // ready/valid come from state only; out_ready never reaches in_ready
  assign main_valid = (state != EMPTY);
  assign in_ready   = resetn & (state != SKID);
  assign out_valid  = main_valid;
  assign accept     = in_valid & in_ready;
  assign xfer       = main_valid & out_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + 32'(main_q.lane_en[i]);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      // a head leaving in the flush cycle has already retired
      if (xfer) cnt_q <= cnt_q + pop;
      if (flush) state <= EMPTY;
      else begin
        case (state)
          EMPTY: if (accept) begin
            main_q <= in_e;
            state  <= FULL;
          end
          FULL: begin
            if (accept && xfer) main_q <= in_e;
            else if (accept) begin
              skid_q <= in_e;
              state  <= SKID;
            end else if (xfer) state <= EMPTY;
          end
          SKID: if (xfer) begin
            main_q <= skid_q;
            state  <= FULL;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cpu_wb_lane_wen #(.REG_W(REG_W)) u_wen (
      .valid (main_valid),
      .en    (main_q.lane_en[g]),
      .wreg  (main_q.wreg[g]),
      .wen   (out_lane_wen[g])
    );
  end

  assign out_wdata  = main_q.wdata;
  assign out_wreg   = main_q.wreg;
  assign out_addr   = main_q.addr;
  assign retire_cnt = cnt_q;
`ifdef WB_HILO_EN
  assign out_w_hi    = main_valid & main_q.w_hi;
  assign out_w_lo    = main_valid & main_q.w_lo;
  assign out_hi_data = main_q.hi_data;
  assign out_lo_data = main_q.lo_data;
`endif
endmodule
